matrix_mac_engine: RTL and testbench

//  Parametrised successor to the fixed 32-bit systolic multiplier: computes C = A*B, or C += A*B, for NxN

---
 rtl/matrix_mac_engine.sv | 159 +++++++++++++++
 tb/tb_matrix_mac_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mac_engine.sv
// NxN signed matrix multiply/accumulate engine: C = A*B or C += A*B.
// A/B are loaded element-wise under stb/ack, and C is drained row-major under stb/ack.
module matrix_mac_engine #(
   parameter int LOG_SIZE = 2,
   parameter int DATA_W   = 16,
   parameter int ACC_W    = 40
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_stb,
   output logic                in_ack,
   input  logic [DATA_W-1:0]   in_a,
   input  logic [DATA_W-1:0]   in_b,
   input  logic                mode,
   output logic                out_stb,
   input  logic                out_ack,
   output logic [ACC_W-1:0]    out_number,
   output logic [LOG_SIZE-1:0] out_row,
   output logic [LOG_SIZE-1:0] out_col,
   output logic                out_last,
   output logic                busy,
   output logic                ovf
);

   localparam int N  = 1 << LOG_SIZE;
   localparam int IW = 2 * LOG_SIZE;
   localparam logic [IW-1:0] LAST = '1;

   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

   state_t r_state, w_next_state;

   logic [DATA_W-1:0]   r_a [N][N];
   logic [DATA_W-1:0]   r_b [N][N];
   logic [ACC_W-1:0]    r_c [N][N];
   logic [IW-1:0]       r_idx;
   logic                r_in_ack;
   logic                r_out_stb;
   logic                r_busy;
   logic                r_ovf;

   logic [LOG_SIZE-1:0] w_hi;
   logic [LOG_SIZE-1:0] w_lo;
   logic                w_in_xfer;
   logic                w_out_xfer;
   logic                w_at_last;
   logic [2*DATA_W-1:0] w_a_ext;
   logic [ACC_W-1:0]    w_c_next [N];
   logic [N-1:0]        w_clip;

   // r_idx is the element index for LOAD/DRAIN and the (r,k) pair for COMPUTE
   assign w_hi      = r_idx[IW-1:LOG_SIZE];
   assign w_lo      = r_idx[LOG_SIZE-1:0];
   assign w_at_last = (r_idx == LAST);

   always_comb begin
      w_in_xfer  = in_stb && r_in_ack;
      w_out_xfer = out_ack && r_out_stb;
      w_a_ext    = {{DATA_W{r_a[w_hi][w_lo][DATA_W-1]}}, r_a[w_hi][w_lo]};
   end

   for (genvar j = 0; j < N; j++) begin : g_col
      logic [2*DATA_W-1:0] w_b_ext;
      logic [2*DATA_W-1:0] w_prod;
      logic [ACC_W:0]      w_sum;
      logic                w_sat_hit;
      logic [ACC_W-1:0]    w_res;

      always_comb begin
         w_b_ext   = {{DATA_W{r_b[w_lo][j][DATA_W-1]}}, r_b[w_lo][j]};
         w_prod    = w_a_ext * w_b_ext;
         w_sum     = {r_c[w_hi][j][ACC_W-1], r_c[w_hi][j]}
                   + {{(ACC_W+1-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
         w_sat_hit = w_sum[ACC_W] ^ w_sum[ACC_W-1];
         w_res     = w_sum[ACC_W-1:0];
         if (w_sat_hit) begin
            w_res = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end
      end

      assign w_clip[j]   = w_sat_hit;
      assign w_c_next[j] = w_res;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_LOAD;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_LOAD:    if (w_in_xfer && w_at_last)  w_next_state = S_COMPUTE;
         S_COMPUTE: if (w_at_last)               w_next_state = S_DRAIN;
         S_DRAIN:   if (w_out_xfer && w_at_last) w_next_state = S_LOAD;
         default:                                w_next_state = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx     <= '0;
         r_in_ack  <= 1'b0;
         r_out_stb <= 1'b0;
         r_busy    <= 1'b0;
         r_ovf     <= 1'b0;
         for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
               r_a[i[LOG_SIZE-1:0]][j[LOG_SIZE-1:0]] <= '0;
               r_b[i[LOG_SIZE-1:0]][j[LOG_SIZE-1:0]] <= '0;
               r_c[i[LOG_SIZE-1:0]][j[LOG_SIZE-1:0]] <= '0;
            end
         end
      end else begin
         r_in_ack  <= (w_next_state == S_LOAD);
         r_busy    <= (w_next_state != S_LOAD);
         // out_stb rises one cycle after entering DRAIN so the final C row has settled
         r_out_stb <= (r_state == S_DRAIN) && (w_next_state == S_DRAIN);
         case (r_state)
            S_LOAD: begin
               if (w_in_xfer) begin
                  r_a[w_hi][w_lo] <= in_a;
                  r_b[w_hi][w_lo] <= in_b;
                  r_idx           <= r_idx + 1'b1;
                  if (r_idx == '0 && !mode) begin
                     r_ovf <= 1'b0;
                     for (int unsigned i = 0; i < N; i++) begin
                        for (int unsigned j = 0; j < N; j++) begin
                           r_c[i[LOG_SIZE-1:0]][j[LOG_SIZE-1:0]] <= '0;
                        end
                     end
                  end
               end
            end
            S_COMPUTE: begin
               for (int unsigned j = 0; j < N; j++) begin
                  r_c[w_hi][j[LOG_SIZE-1:0]] <= w_c_next[j[LOG_SIZE-1:0]];
               end
               if (|w_clip) r_ovf <= 1'b1;
               r_idx <= r_idx + 1'b1;
            end
            S_DRAIN: begin
               if (w_out_xfer) r_idx <= r_idx + 1'b1;
            end
            default: r_idx <= '0;
         endcase
      end
   end

   assign in_ack     = r_in_ack;
   assign out_stb    = r_out_stb;
   assign busy       = r_busy;
   assign ovf        = r_ovf;
   assign out_number = r_out_stb ? r_c[w_hi][w_lo] : '0;
   assign out_row    = r_out_stb ? w_hi : '0;
   assign out_col    = r_out_stb ? w_lo : '0;
   assign out_last   = r_out_stb && w_at_last;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine: a 40-bit and a 32-bit accumulator instance share one
// input stream, and a scoreboard of reference products is checked as results drain.
module tb_matrix_mac_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_stb = 1'b0;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        mode = 1'b0;
   logic        out_ack = 1'b0;

   logic        in_ack, out_stb, out_last, busy, ovf;
   logic [39:0] out_number;
   logic [1:0]  out_row, out_col;
   logic        in_ack_s, out_stb_s, out_last_s, busy_s, ovf_s;
   logic [31:0] out_number_s;
   logic [1:0]  out_row_s, out_col_s;

   always #5 clk = ~clk;

   matrix_mac_engine #(.LOG_SIZE(2), .DATA_W(16), .ACC_W(40)) u_dut (
      .clk(clk), .rst(rst), .in_stb(in_stb), .in_ack(in_ack), .in_a(in_a), .in_b(in_b),
      .mode(mode), .out_stb(out_stb), .out_ack(out_ack), .out_number(out_number),
      .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy), .ovf(ovf)
   );

   matrix_mac_engine #(.LOG_SIZE(2), .DATA_W(16), .ACC_W(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_stb(in_stb), .in_ack(in_ack_s), .in_a(in_a), .in_b(in_b),
      .mode(mode), .out_stb(out_stb_s), .out_ack(out_ack), .out_number(out_number_s),
      .out_row(out_row_s), .out_col(out_col_s), .out_last(out_last_s), .busy(busy_s), .ovf(ovf_s)
   );

   typedef struct {
      longint v40;
      longint v32;
      int     row;
      int     col;
      bit     last;
   } exp_t;

   exp_t   sb[$];
   exp_t   mon_e;
   longint m40[4][4];
   longint m32[4][4];
   bit     movf40 = 1'b0;
   bit     movf32 = 1'b0;
   int     n_checks = 0;
   int     n_fail = 0;
   int     n_out = 0;
   int     n_in = 0;
   int     ident[16], seq[16], neg[16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            m40[i][j] = 0;
            m32[i][j] = 0;
         end
      movf40 = 1'b0;
      movf32 = 1'b0;
   endtask

   // Reference: per-step saturating accumulation in k order, both accumulator widths
   task automatic model_load(input bit m, input int a[16], input int b[16]);
      longint p, s, lim;
      exp_t   e;
      if (!m) clear_model();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++) begin
               p   = longint'(a[i*4+k]) * longint'(b[k*4+j]);
               lim = longint'(1) << 39;
               s   = m40[i][j] + p;
               if (s > lim - 1) begin s = lim - 1; movf40 = 1'b1; end
               if (s < -lim)    begin s = -lim;    movf40 = 1'b1; end
               m40[i][j] = s;
               lim = longint'(1) << 31;
               s   = m32[i][j] + p;
               if (s > lim - 1) begin s = lim - 1; movf32 = 1'b1; end
               if (s < -lim)    begin s = -lim;    movf32 = 1'b1; end
               m32[i][j] = s;
            end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            e.v40  = m40[i][j];
            e.v32  = m32[i][j];
            e.row  = i;
            e.col  = j;
            e.last = (i == 3 && j == 3);
            sb.push_back(e);
         end
   endtask

   always @(negedge clk) begin
      if (in_stb && in_ack) n_in++;
      if (out_stb && out_ack) begin
         n_out++;
         if (sb.size() == 0) begin
            chk("unexpected_output", 64'(sb.size()), 64'd1);
         end else begin
            mon_e = sb.pop_front();
            chk("out_number", 64'(out_number), 64'(mon_e.v40[39:0]));
            chk("out_number_32", 64'(out_number_s), 64'(mon_e.v32[31:0]));
            chk("out_row", 64'(out_row), 64'(mon_e.row));
            chk("out_col", 64'(out_col), 64'(mon_e.col));
            chk("out_last", 64'(out_last), 64'(mon_e.last));
            chk("out_stb_32", 64'(out_stb_s), 64'd1);
         end
      end
   end

   task automatic load(input bit m, input int a[16], input int b[16], input bit toggle, input bit push);
      int   budget;
      logic got;
      if (push) model_load(m, a, b);
      for (int idx = 0; idx < 16; idx++) begin
         in_a   = 16'(a[idx]);
         in_b   = 16'(b[idx]);
         mode   = (idx == 0) ? m : !m;
         in_stb = 1'b1;
         budget = 0;
         got    = 1'b0;
         while (!got && budget < 200) begin
            @(negedge clk);
            got = in_ack;
            @(posedge clk);
            #1;
            budget++;
         end
         if (!got) begin
            chk("load_timeout", 64'(got), 64'd1);
            break;
         end
         if (toggle && idx != 15) begin
            in_stb = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      in_stb = 1'b0;
      mode   = 1'b0;
   endtask

   task automatic wait_drain();
      int c = 0;
      while (sb.size() != 0 && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk("drain_done", 64'(sb.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, lat, c;
      for (int i = 0; i < 16; i++) begin
         ident[i] = (i / 4 == i % 4) ? 1 : 0;
         seq[i]   = i + 1;
         neg[i]   = -32768;
      end
      clear_model();

      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ack", 64'(in_ack), 64'd0);
      chk("rst_out_stb", 64'(out_stb), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_out_number", 64'(out_number), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("in_ack_before_edge", 64'(in_ack), 64'd0);
      @(posedge clk);
      #1;
      chk("in_ack_after_release", 64'(in_ack), 64'd1);
      out_ack = 1'b1;

      // 1: identity * seq, overwrite, latency
      n0 = n_in;
      load(1'b0, ident, seq, 1'b0, 1'b1);
      chk("t1_xfer_count", 64'(n_in - n0), 64'd16);
      chk("t1_in_ack_low", 64'(in_ack), 64'd0);
      lat = 0;
      while (!out_stb && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("t1_latency", 64'(lat), 64'd17);
      chk("t1_busy", 64'(busy), 64'd1);
      wait_drain();
      chk("t1_ovf", 64'(ovf), 64'(movf40));
      chk("t1_busy_idle", 64'(busy), 64'd0);
      chk("t1_in_ack_idle", 64'(in_ack), 64'd1);

      // 2: accumulate then overwrite
      load(1'b1, ident, seq, 1'b0, 1'b1);
      wait_drain();
      load(1'b0, ident, seq, 1'b0, 1'b1);
      wait_drain();

      // 3: saturation on the 32-bit instance, then cleared by an overwrite load
      load(1'b0, neg, neg, 1'b0, 1'b1);
      wait_drain();
      chk("t3_ovf40", 64'(ovf), 64'(movf40));
      chk("t3_ovf32", 64'(ovf_s), 64'(movf32));
      chk("t3_ovf32_set", 64'(ovf_s), 64'd1);
      load(1'b0, ident, seq, 1'b0, 1'b1);
      wait_drain();
      chk("t3_ovf32_cleared", 64'(ovf_s), 64'd0);

      // 4: sink stall on the fifth element
      load(1'b0, ident, seq, 1'b0, 1'b1);
      n0 = n_out;
      c  = 0;
      while (n_out - n0 < 4 && c < 100) begin
         @(posedge clk);
         #1;
         c++;
      end
      out_ack = 1'b0;
      for (int s = 0; s < 10; s++) begin
         @(negedge clk);
         chk("t4_hold_number", 64'(out_number), 64'd5);
         chk("t4_hold_stb", 64'(out_stb), 64'd1);
         chk("t4_hold_in_ack", 64'(in_ack), 64'd0);
         chk("t4_hold_row", 64'(out_row), 64'd1);
         chk("t4_hold_col", 64'(out_col), 64'd0);
      end
      @(posedge clk);
      #1 out_ack = 1'b1;
      wait_drain();

      // 5: gapped source
      n0 = n_in;
      load(1'b0, ident, seq, 1'b1, 1'b1);
      chk("t5_xfer_count", 64'(n_in - n0), 64'd16);
      wait_drain();

      // 6: reset mid-compute, then accumulate from a cleared C
      load(1'b0, ident, seq, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("t6_busy_compute", 64'(busy), 64'd1);
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         chk("t6_rst_out_stb", 64'(out_stb), 64'd0);
         chk("t6_rst_number", 64'(out_number), 64'd0);
         chk("t6_rst_busy", 64'(busy), 64'd0);
         chk("t6_rst_in_ack", 64'(in_ack), 64'd0);
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      clear_model();
      n0 = n_out;
      repeat (30) @(posedge clk);
      #1;
      chk("t6_no_output", 64'(n_out - n0), 64'd0);
      load(1'b1, ident, seq, 1'b0, 1'b1);
      wait_drain();
      chk("t6_ovf", 64'(ovf), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
